// File: rtl/sc_master.sv
// Slow-control bus master: takes one request at a time, runs the SETUP/OP/RELEASE
// ack handshake on the sc_* bus, and returns the reply (or a timeout) on rsp_*.
module sc_master #(
  parameter int unsigned TIMEOUT     = 1024,
  parameter logic [31:0] ERR_TIMEOUT = 32'hEEEE0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_port,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_subaddr,
  input  logic [31:0] cmd_data,
  input  logic        cmd_wr,
  input  logic        cmd_last,
  output logic [15:0] sc_port,
  output logic [31:0] sc_addr,
  output logic [31:0] sc_subaddr,
  output logic [31:0] sc_data,
  output logic        sc_frame,
  output logic        sc_op,
  output logic        sc_wr,
  input  logic        sc_ack,
  input  logic [31:0] sc_rply_data,
  input  logic [31:0] sc_rply_error,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [31:0] rsp_error,
  output logic        rsp_timeout,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, SETUP, OP, RELEASE, RESP} state_e;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        last_q, last_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic [15:0] sc_port_q, sc_port_d;
  logic [31:0] sc_addr_q, sc_addr_d;
  logic [31:0] sc_subaddr_q, sc_subaddr_d;
  logic [31:0] sc_data_q, sc_data_d;
  logic        sc_frame_q, sc_frame_d;
  logic        sc_op_q, sc_op_d;
  logic        sc_wr_q, sc_wr_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [31:0] rsp_error_q, rsp_error_d;
  logic        rsp_timeout_q, rsp_timeout_d;
  logic        busy_q, busy_d;
  logic        waiting;
  logic        expired;

  assign waiting = (state_q == SETUP) || (state_q == OP) || (state_q == RELEASE);
  assign expired = (cnt_q == CNT_LAST);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    last_d        = last_q;
    cmd_ready_d   = cmd_ready_q;
    sc_port_d     = sc_port_q;
    sc_addr_d     = sc_addr_q;
    sc_subaddr_d  = sc_subaddr_q;
    sc_data_d     = sc_data_q;
    sc_frame_d    = sc_frame_q;
    sc_op_d       = sc_op_q;
    sc_wr_d       = sc_wr_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    rsp_error_d   = rsp_error_q;
    rsp_timeout_d = rsp_timeout_q;

    if (state_q == IDLE) begin
      if (cmd_valid) begin
        sc_port_d     = cmd_port;
        sc_addr_d     = cmd_addr;
        sc_subaddr_d  = cmd_subaddr;
        sc_data_d     = cmd_data;
        sc_wr_d       = cmd_wr;
        sc_frame_d    = 1'b1;
        last_d        = cmd_last;
        rsp_timeout_d = 1'b0;
        cnt_d         = '0;
        cmd_ready_d   = 1'b0;
        state_d       = SETUP;
      end
    end else if (waiting) begin
      // Timeout wins over a same-cycle ack so an ack racing the limit is never half-consumed.
      if (expired) begin
        rsp_data_d    = '0;
        rsp_error_d   = ERR_TIMEOUT;
        rsp_timeout_d = 1'b1;
        sc_op_d       = 1'b0;
        sc_frame_d    = 1'b0;
        rsp_valid_d   = 1'b1;
        state_d       = RESP;
      end else begin
        cnt_d = cnt_q + 16'd1;
        if (state_q == SETUP && !sc_ack) begin
          sc_op_d = 1'b1;
          cnt_d   = '0;
          state_d = OP;
        end else if (state_q == OP && sc_ack) begin
          rsp_data_d  = sc_rply_data;
          rsp_error_d = sc_rply_error;
          sc_op_d     = 1'b0;
          cnt_d       = '0;
          state_d     = RELEASE;
        end else if (state_q == RELEASE && !sc_ack) begin
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
    end else if (state_q == RESP) begin
      if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        if (last_q) sc_frame_d = 1'b0;
        cmd_ready_d = 1'b1;
        state_d     = IDLE;
      end
    end else begin
      state_d = IDLE;
    end

    busy_d = (state_d != IDLE) || sc_frame_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      last_q        <= 1'b0;
      cmd_ready_q   <= 1'b1;
      sc_port_q     <= '0;
      sc_addr_q     <= '0;
      sc_subaddr_q  <= '0;
      sc_data_q     <= '0;
      sc_frame_q    <= 1'b0;
      sc_op_q       <= 1'b0;
      sc_wr_q       <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_error_q   <= '0;
      rsp_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      last_q        <= last_d;
      cmd_ready_q   <= cmd_ready_d;
      sc_port_q     <= sc_port_d;
      sc_addr_q     <= sc_addr_d;
      sc_subaddr_q  <= sc_subaddr_d;
      sc_data_q     <= sc_data_d;
      sc_frame_q    <= sc_frame_d;
      sc_op_q       <= sc_op_d;
      sc_wr_q       <= sc_wr_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_error_q   <= rsp_error_d;
      rsp_timeout_q <= rsp_timeout_d;
      busy_q        <= busy_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign sc_port     = sc_port_q;
  assign sc_addr     = sc_addr_q;
  assign sc_subaddr  = sc_subaddr_q;
  assign sc_data     = sc_data_q;
  assign sc_frame    = sc_frame_q;
  assign sc_op       = sc_op_q;
  assign sc_wr       = sc_wr_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_error   = rsp_error_q;
  assign rsp_timeout = rsp_timeout_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_sc_master.sv
// Bench for sc_master: a transaction-level responder/driver plus a per-cycle compare
// process that checks the DUT against queue-based expectations.
module tb_sc_master;
  localparam int unsigned TO  = 16;
  localparam logic [31:0] ERR = 32'hEEEE0001;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready, cmd_wr, cmd_last;
  logic [15:0] cmd_port, sc_port;
  logic [31:0] cmd_addr, cmd_subaddr, cmd_data;
  logic [31:0] sc_addr, sc_subaddr, sc_data;
  logic        sc_frame, sc_op, sc_wr, sc_ack;
  logic [31:0] sc_rply_data, sc_rply_error;
  logic        rsp_valid, rsp_ready, rsp_timeout, busy;
  logic [31:0] rsp_data, rsp_error;

  sc_master #(.TIMEOUT(TO), .ERR_TIMEOUT(ERR)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_port(cmd_port), .cmd_addr(cmd_addr), .cmd_subaddr(cmd_subaddr), .cmd_data(cmd_data),
    .cmd_wr(cmd_wr), .cmd_last(cmd_last),
    .sc_port(sc_port), .sc_addr(sc_addr), .sc_subaddr(sc_subaddr), .sc_data(sc_data),
    .sc_frame(sc_frame), .sc_op(sc_op), .sc_wr(sc_wr),
    .sc_ack(sc_ack), .sc_rply_data(sc_rply_data), .sc_rply_error(sc_rply_error),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_error(rsp_error), .rsp_timeout(rsp_timeout), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [31:0] err;
    logic        to;
  } rsp_t;

  rsp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          chk_en = 0, in_flight = 0, frame_open = 0, last_to = 0, cur_to = 0;
  bit          lit_en = 0;
  logic [31:0] lit_data, lit_err;
  logic [15:0] cur_port;
  logic [31:0] cur_addr, cur_sub, cur_data;
  logic        cur_wr;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Per-cycle comparison against the transaction model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cmd_ready", 32'(cmd_ready), 32'(!in_flight));
      check("busy", 32'(busy), 32'(in_flight || frame_open));
      if (!in_flight) begin
        check("idle_frame", 32'(sc_frame), 32'(frame_open));
        check("idle_op", 32'(sc_op), 0);
        check("idle_valid", 32'(rsp_valid), 0);
        check("idle_timeout", 32'(rsp_timeout), 32'(last_to));
      end else if (!cur_to) begin
        check("frame_high", 32'(sc_frame), 1);
        check("sc_port", 32'(sc_port), 32'(cur_port));
        check("sc_addr", sc_addr, cur_addr);
        check("sc_subaddr", sc_subaddr, cur_sub);
        check("sc_data", sc_data, cur_data);
        check("sc_wr", 32'(sc_wr), 32'(cur_wr));
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rsp_unexpected: got rsp_valid=1 expected no response at %0t", $time);
        end else begin
          check("rsp_data", rsp_data, exp_q[0].data);
          check("rsp_error", rsp_error, exp_q[0].err);
          check("rsp_timeout", 32'(rsp_timeout), 32'(exp_q[0].to));
          if (rsp_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction. ack_dly: cycles after sc_op rises before the responder acks;
  // the master must time out when the ack would be sampled with the counter at TO-1.
  task automatic run_txn(input logic [15:0] p, input logic [31:0] a, input logic [31:0] sa,
                         input logic [31:0] d, input logic wr, input logic lst,
                         input int stale, input int ack_dly, input int rel_dly, input int rdy_dly,
                         input logic [31:0] rdata, input logic [31:0] rerr);
    rsp_t e;
    bit   to;
    to = (ack_dly >= int'(TO) - 1);
    sc_ack      = (stale > 0);
    cmd_valid   = 1'b1;
    cmd_port    = p;
    cmd_addr    = a;
    cmd_subaddr = sa;
    cmd_data    = d;
    cmd_wr      = wr;
    cmd_last    = lst;
    tick();
    cmd_valid   = 1'b0;
    cmd_port    = 16'($urandom);
    cmd_addr    = $urandom;
    cmd_subaddr = $urandom;
    cmd_data    = $urandom;
    cmd_wr      = 1'($urandom);
    cmd_last    = 1'($urandom);
    in_flight = 1;
    cur_port  = p;
    cur_addr  = a;
    cur_sub   = sa;
    cur_data  = d;
    cur_wr    = wr;
    cur_to    = to;
    e.data = to ? 32'h0 : rdata;
    e.err  = to ? ERR : rerr;
    e.to   = to;
    exp_q.push_back(e);

    for (int i = 0; i < stale; i++) begin
      check("stale_op", 32'(sc_op), 0);
      tick();
    end
    sc_ack = 1'b0;
    check("setup_op", 32'(sc_op), 0);
    tick();
    check("op_rise", 32'(sc_op), 1);

    if (to) begin
      for (int i = 0; i < int'(TO); i++) begin
        if (i == int'(TO) - 1) check("op_hold", 32'(sc_op), 1);
        if (i == ack_dly) begin
          sc_ack        = 1'b1;
          sc_rply_data  = rdata;
          sc_rply_error = rerr;
        end
        tick();
      end
      sc_ack = 1'b0;
      check("to_op", 32'(sc_op), 0);
      check("to_frame", 32'(sc_frame), 0);
      check("to_valid", 32'(rsp_valid), 1);
      check("to_flag", 32'(rsp_timeout), 1);
    end else begin
      for (int i = 0; i < ack_dly; i++) tick();
      check("op_wait", 32'(sc_op), 1);
      sc_ack        = 1'b1;
      sc_rply_data  = rdata;
      sc_rply_error = rerr;
      tick();
      check("op_fall", 32'(sc_op), 0);
      check("rel_valid", 32'(rsp_valid), 0);
      sc_rply_data  = $urandom;
      sc_rply_error = $urandom;
      for (int i = 0; i < rel_dly; i++) begin
        tick();
        check("rel_hold_valid", 32'(rsp_valid), 0);
      end
      sc_ack = 1'b0;
      tick();
      check("rsp_rise", 32'(rsp_valid), 1);
    end
    if (lit_en) begin
      check("lit_data", rsp_data, lit_data);
      check("lit_err", rsp_error, lit_err);
    end

    for (int i = 0; i < rdy_dly; i++) tick();
    rsp_ready = 1'b1;
    tick();
    rsp_ready  = 1'b0;
    in_flight  = 0;
    frame_open = !lst && !to;
    last_to    = to;
    check("hs_valid", 32'(rsp_valid), 0);
  endtask

  task automatic check_reset_state();
    check("rst_cmd_ready", 32'(cmd_ready), 1);
    check("rst_frame", 32'(sc_frame), 0);
    check("rst_op", 32'(sc_op), 0);
    check("rst_valid", 32'(rsp_valid), 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_error", rsp_error, 0);
    check("rst_timeout", 32'(rsp_timeout), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_sc_addr", sc_addr, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int r, ad;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_port = '0; cmd_addr = '0; cmd_subaddr = '0; cmd_data = '0;
    cmd_wr = 1'b0; cmd_last = 1'b0;
    sc_ack = 1'b0; sc_rply_data = '0; sc_rply_error = '0; rsp_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_reset_state();
    chk_en = 1;

    // Single read, literal reply.
    lit_en = 1; lit_data = 32'h0001E456; lit_err = 32'h0;
    run_txn(16'h1777, 32'h2, 32'h0, 32'h0, 1'b0, 1'b1, 0, 3, 1, 2, 32'h0001E456, 32'h0);
    check("read_frame_closed", 32'(sc_frame), 0);
    lit_en = 0;

    // Two-operation write frame.
    run_txn(16'h0042, 32'h10, 32'h1, 32'hA5A5A5A5, 1'b1, 1'b0, 0, 1, 0, 0, 32'h0, 32'h0);
    check("frame_open_between", 32'(sc_frame), 1);
    tick();
    run_txn(16'h0042, 32'h14, 32'h1, 32'h5A5A5A5A, 1'b1, 1'b1, 0, 2, 0, 1, 32'h0, 32'h0);
    check("frame_closed_after", 32'(sc_frame), 0);

    // Timeouts: ack never comes, ack exactly at the limit, and ack one cycle before it.
    lit_en = 1; lit_data = 32'h0; lit_err = 32'hEEEE0001;
    run_txn(16'h0001, 32'h3, 32'h0, 32'h0, 1'b0, 1'b0, 0, 1000, 0, 1, 32'h12345678, 32'h1);
    check("to_cmd_ready", 32'(cmd_ready), 1);
    run_txn(16'h0002, 32'h4, 32'h0, 32'h0, 1'b0, 1'b1, 0, 15, 0, 0, 32'h87654321, 32'h2);
    lit_data = 32'hCAFE0014; lit_err = 32'h5;
    run_txn(16'h0003, 32'h5, 32'h0, 32'h0, 1'b0, 1'b1, 0, 14, 0, 0, 32'hCAFE0014, 32'h5);
    lit_en = 0;

    // Stale ack dropping 5 cycles after accept; then a long rsp_ready stall.
    run_txn(16'h0004, 32'h6, 32'h7, 32'h8, 1'b1, 1'b1, 5, 2, 1, 0, 32'h11, 32'h0);
    run_txn(16'h0005, 32'h9, 32'hA, 32'hB, 1'b0, 1'b1, 0, 0, 0, 10, 32'h22, 32'h33);

    // Reset during OP, then a normal command.
    cmd_valid = 1'b1; cmd_port = 16'h0ABC; cmd_addr = 32'h77; cmd_subaddr = 32'h0;
    cmd_data = 32'h0; cmd_wr = 1'b0; cmd_last = 1'b1;
    tick();
    cmd_valid = 1'b0;
    in_flight = 1; cur_to = 0;
    cur_port = 16'h0ABC; cur_addr = 32'h77; cur_sub = 32'h0; cur_data = 32'h0; cur_wr = 1'b0;
    tick();
    check("pre_rst_op", 32'(sc_op), 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_flight = 0; frame_open = 0; last_to = 0;
    exp_q.delete();
    check_reset_state();
    run_txn(16'h0ABC, 32'h78, 32'h1, 32'h2, 1'b0, 1'b1, 0, 3, 0, 0, 32'hDEADBEEF, 32'h0);

    // Randomized transactions.
    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 9));
      ad = (r == 0) ? 15 : (r == 1) ? 40 : int'($urandom_range(0, 14));
      run_txn(16'($urandom), $urandom, $urandom, $urandom, 1'($urandom), 1'($urandom),
              int'($urandom_range(0, 4)), ad, int'($urandom_range(0, 3)),
              int'($urandom_range(0, 4)), $urandom, $urandom);
      if ($urandom_range(0, 3) == 0) repeat (int'($urandom_range(1, 3))) tick();
    end

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
